// File: rtl/vram_burst_fetch.sv
// Burst-read sequencer: fetches consecutive 32-bit VRAM words over a strobe/ack port and streams them out through a FIFO.
// Optional macro VRAM_BURST_FETCH_STATS_EN adds the stall_cycles lost-arbitration counter.
module vram_burst_fetch #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LEN_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [14:0]      start_addr,
    input  logic [LEN_W-1:0] length,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [14:0]      bus_addr,
    output logic             bus_strobe,
    input  logic             bus_ack,
    input  logic [31:0]      bus_rddata,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef VRAM_BURST_FETCH_STATS_EN
    ,
    output logic [15:0]      stall_cycles
`endif
);
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  last_addr_q;
    logic [LEN_W-1:0]   recv_left_q;
    logic [LEN_W-1:0]   issue_left;
    logic               strobe_q;
    logic               ack_v, accept, flush, busy_d, done_d;

    logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q, rd_next;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push, pop, head_bypass;

    // Next-state, request generation and address presentation
    always_comb begin
        state_d    = state_q;
        busy_d     = busy;
        done_d     = 1'b0;
        accept     = 1'b0;
        flush      = 1'b0;
        ack_v      = 1'b0;
        bus_strobe = 1'b0;
        bus_addr   = last_addr_q;
        issue_left = recv_left_q;
        if (abort) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            flush   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        accept = 1'b1;
                        if (length != '0) begin
                            state_d = FETCH;
                            busy_d  = 1'b1;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                FETCH: begin
                    ack_v      = bus_ack & strobe_q;
                    issue_left = recv_left_q - LEN_W'(ack_v);
                    if (ack_v) bus_addr = last_addr_q + ADDR_W'(1);
                    // an ungranted strobe still reserves its FIFO slot until resolved
                    bus_strobe = (issue_left != '0) &&
                                 ((count_q + CNT_W'(strobe_q)) < CNT_W'(FIFO_DEPTH));
                    if (issue_left == '0) state_d = DRAIN;
                end
                DRAIN: begin
                    if (count_q == '0) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Burst address and word tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            last_addr_q <= '0;
            recv_left_q <= '0;
            strobe_q    <= 1'b0;
        end else begin
            strobe_q <= bus_strobe;
            if (accept && length != '0) begin
                last_addr_q <= start_addr;
                recv_left_q <= length;
            end else if (state_q == FETCH) begin
                last_addr_q <= bus_addr;
                if (ack_v) recv_left_q <= recv_left_q - LEN_W'(1);
            end
        end
    end

    assign push        = ack_v;
    assign pop         = out_valid & out_ready & ~flush;
    assign count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    assign rd_next     = rd_ptr_q + PTR_W'(pop);
    assign head_bypass = push && ((count_q - CNT_W'(pop)) == '0);

    // FIFO control; out_data is kept equal to the head entry
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            rd_ptr_q  <= rd_next;
            count_q   <= count_d;
            out_valid <= (count_d != '0);
            if (head_bypass)         out_data <= bus_rddata;
            else if (count_d != '0)  out_data <= mem_q[rd_next];
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus_rddata;
    end

`ifdef VRAM_BURST_FETCH_STATS_EN
    // Cycles whose previous strobe lost arbitration; saturating
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            stall_cycles <= '0;
        end else if (state_q == FETCH && strobe_q && !bus_ack && stall_cycles != 16'hFFFF) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

    fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        push |-> (count_q < CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_vram_burst_fetch.sv
// Self-checking bench for vram_burst_fetch: directed scenarios plus randomized bursts against a queue-based model.
`timescale 1ns/1ps
module tb_vram_burst_fetch;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [14:0] start_addr = '0;
    logic [7:0]  length = '0;
    logic        abort = 1'b0;
    logic        busy, done, bus_strobe, out_valid;
    logic [14:0] bus_addr;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rddata = '0;
    logic [31:0] out_data;
    logic        out_ready = 1'b1;
`ifdef VRAM_BURST_FETCH_STATS_EN
    logic [15:0] stall_cycles;
    int          m_stall = 0;
`endif

    vram_burst_fetch #(.FIFO_DEPTH(DEPTH), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .length(length),
        .abort(abort), .busy(busy), .done(done), .bus_addr(bus_addr), .bus_strobe(bus_strobe),
        .bus_ack(bus_ack), .bus_rddata(bus_rddata), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef VRAM_BURST_FETCH_STATS_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0, cyc = 0;
    // model of the burst: phase flags, progress and expected FIFO contents
    bit          m_fetch = 0, m_drain = 0, m_busy = 0, m_done = 0, m_inflight = 0, m_addr_zero = 1;
    int          m_len = 0, m_recv = 0;
    logic [14:0] m_base = '0;
    logic [31:0] q[$];
    // environment and logs
    int          ready_pct = 100, deny_pct = 0, deny_left = 0;
    bit          inject_ack = 0, prev_abort = 0;
    logic        ack_nxt = 1'b0, abort_strobe = 1'b0, post_abort_valid = 1'b0;
    logic [31:0] data_nxt = '0;
    logic [14:0] slog[$];
    logic [31:0] plog[$];
    int          done_cnt = 0, first_strobe_cyc = -1, first_valid_cyc = -1;

    function automatic logic [31:0] data_of(input logic [14:0] a);
        return {1'b0, a, 1'b1, ~a};
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // One clock: check outputs mid-cycle, play the VRAM port, advance the model, drive the next cycle
    task automatic step();
        logic ack_eff, exp_strobe, idle, was_empty;
        @(negedge clk);
        cyc++;
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("out_data", out_data, q[0]);
`ifdef VRAM_BURST_FETCH_STATS_EN
        chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
`endif
        ack_eff    = bus_ack && m_fetch && m_inflight;
        exp_strobe = !abort && m_fetch && (m_recv + int'(ack_eff) < m_len) &&
                     (q.size() + int'(m_inflight) < DEPTH);
        chk("bus_strobe", 32'(bus_strobe), 32'(exp_strobe));
        if (exp_strobe) chk("bus_addr", 32'(bus_addr), 32'(15'(m_base + 15'(m_recv + int'(ack_eff)))));
        if (m_addr_zero) chk("bus_addr_after_reset", 32'(bus_addr), 32'h0);

        if (bus_strobe) slog.push_back(bus_addr);
        if (bus_strobe && first_strobe_cyc < 0) first_strobe_cyc = cyc;
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (out_valid && out_ready) plog.push_back(out_data);
        if (done) done_cnt++;
        if (abort) abort_strobe = bus_strobe;
        if (prev_abort) post_abort_valid = out_valid;
        prev_abort = abort;

        ack_nxt  = 1'b0;
        data_nxt = 32'hDEAD_BEEF;
        if (bus_strobe) begin
            if (deny_left > 0) deny_left--;
            else if (int'($urandom_range(99)) >= deny_pct) begin
                ack_nxt  = 1'b1;
                data_nxt = data_of(bus_addr);
            end
        end

        idle      = !m_fetch && !m_drain;
        was_empty = (q.size() == 0);
        if (rst) begin
            m_fetch = 0; m_drain = 0; m_busy = 0; m_done = 0; m_inflight = 0; m_addr_zero = 1;
            q.delete();
`ifdef VRAM_BURST_FETCH_STATS_EN
            m_stall = 0;
`endif
        end else begin
`ifdef VRAM_BURST_FETCH_STATS_EN
            if (m_fetch && m_inflight && !bus_ack && m_stall < 'hFFFF) m_stall++;
`endif
            if (abort) begin
                m_fetch = 0; m_drain = 0; m_busy = 0; m_done = 0; m_inflight = 0;
                q.delete();
            end else begin
                m_done = 0;
                if (!was_empty && out_ready) void'(q.pop_front());
                if (idle && start) begin
`ifdef VRAM_BURST_FETCH_STATS_EN
                    m_stall = 0;
`endif
                    if (length != 0) begin
                        m_fetch = 1; m_busy = 1; m_len = int'(length); m_recv = 0;
                        m_base = start_addr; m_addr_zero = 0;
                    end else begin
                        m_done = 1;
                    end
                end else if (m_fetch) begin
                    if (ack_eff) begin
                        q.push_back(data_of(15'(m_base + 15'(m_recv))));
                        m_recv++;
                    end
                    if (m_recv == m_len) begin
                        m_fetch = 0; m_drain = 1;
                    end
                end else if (m_drain && was_empty) begin
                    m_drain = 0; m_busy = 0; m_done = 1;
                end
                m_inflight = exp_strobe;
            end
        end

        @(posedge clk);
        #1;
        bus_ack    = ack_nxt | inject_ack;
        bus_rddata = (inject_ack && !ack_nxt) ? 32'hBAD0_0BAD : data_nxt;
        inject_ack = 0;
        start      = 1'b0;
        abort      = 1'b0;
        out_ready  = int'($urandom_range(99)) < ready_pct;
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int n = 0;
        while ((m_busy || m_fetch || m_drain || m_done) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: burst still active after %0d cycles, required idle", name, budget);
        end
        step();
    endtask

    task automatic clear_logs();
        slog.delete(); plog.delete();
        done_cnt = 0; first_strobe_cyc = -1; first_valid_cyc = -1;
    endtask

    task automatic begin_burst(input logic [14:0] a, input int len);
        start_addr = a; length = 8'(len); start = 1'b1;
    endtask

    logic [14:0] wrap_exp [4] = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
    logic [14:0] lost_exp [5] = '{15'h0100, 15'h0100, 15'h0100, 15'h0101, 15'h0102};

    initial begin
        int mark, n;
        repeat (2) @(posedge clk);
        #1;
        // reset held one more checked cycle with a stray ack landing right after it
        inject_ack = 1; step();
        rst = 1'b0;
        step(); step();
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_out_data", out_data, 32'h0);

        // uncontended burst, plus an ignored start while busy
        clear_logs();
        mark = cyc + 1;
        begin_burst(15'h0100, 4); step();
        begin_burst(15'h0555, 9); step();
        run_until_idle("uncontended", 200);
        chk("t1_strobe_count", 32'(slog.size()), 32'd4);
        for (int i = 0; i < slog.size(); i++) chk("t1_addr", 32'(slog[i]), 32'h100 + 32'(i));
        chk("t1_first_word", plog.size() > 0 ? plog[0] : 32'hX, 32'h0100_FEFF);
        chk("t1_words", 32'(plog.size()), 32'd4);
        chk("t1_done_pulses", 32'(done_cnt), 32'd1);
        chk("t1_strobe_latency", 32'(first_strobe_cyc - mark), 32'd1);
        chk("t1_valid_latency", 32'(first_valid_cyc - mark), 32'd3);

        // lost grants: first two strobes denied
        clear_logs();
        deny_left = 2;
        begin_burst(15'h0100, 3); step();
        run_until_idle("lost_grants", 200);
        chk("t2_strobe_count", 32'(slog.size()), 32'd5);
        for (int i = 0; i < 5 && i < slog.size(); i++) chk("t2_addr", 32'(slog[i]), 32'(lost_exp[i]));
        chk("t2_words", 32'(plog.size()), 32'd3);
`ifdef VRAM_BURST_FETCH_STATS_EN
        chk("t2_stall_cycles", 32'(stall_cycles), 32'd2);
`endif

        // backpressure: consumer stalled, FIFO fills to depth
        clear_logs();
        ready_pct = 0;
        begin_burst(15'h0040, 20); step();
        repeat (40) step();
        chk("t3_strobes_while_stalled", 32'(slog.size()), 32'd8);
        chk("t3_out_valid", 32'(out_valid), 32'd1);
        ready_pct = 100;
        run_until_idle("backpressure", 300);
        chk("t3_words", 32'(plog.size()), 32'd20);
        for (int i = 0; i < plog.size(); i++) chk("t3_data", plog[i], data_of(15'(15'h0040 + 15'(i))));
        chk("t3_done_pulses", 32'(done_cnt), 32'd1);

        // address wrap
        clear_logs();
        begin_burst(15'h7FFE, 4); step();
        run_until_idle("wrap", 200);
        chk("t4_strobe_count", 32'(slog.size()), 32'd4);
        for (int i = 0; i < 4 && i < slog.size(); i++) chk("t4_addr", 32'(slog[i]), 32'(wrap_exp[i]));

        // abort after three acks, stray ack in the following cycle, then a fresh burst
        clear_logs();
        ready_pct = 0;
        begin_burst(15'h0200, 10); step();
        n = 0;
        while (m_recv < 3 && n < 50) begin step(); n++; end
        if (n >= 50) begin
            n_checks++; n_fail++;
            $display("FAIL abort_setup: got %0d acks, required 3", m_recv);
        end
        ready_pct = 100;
        abort = 1'b1; inject_ack = 1; step();
        plog.delete(); slog.delete();
        begin_burst(15'h0600, 2); step();
        run_until_idle("after_abort", 200);
        chk("t5_abort_strobe", 32'(abort_strobe), 32'h0);
        chk("t5_valid_after_abort", 32'(post_abort_valid), 32'h0);
        chk("t5_done_pulses", 32'(done_cnt), 32'd1);
        chk("t5_new_words", 32'(plog.size()), 32'd2);
        for (int i = 0; i < 2 && i < plog.size(); i++) chk("t5_new_data", plog[i], data_of(15'(15'h0600 + 15'(i))));

        // zero length: done pulse only
        clear_logs();
        begin_burst(15'h0123, 0); step();
        step(); step();
        chk("t6_done_pulses", 32'(done_cnt), 32'd1);
        chk("t6_strobes", 32'(slog.size()), 32'd0);

        // reset in the middle of a burst
        ready_pct = 50;
        begin_burst(15'h0700, 30); step();
        repeat (6) step();
        rst = 1'b1; step();
        rst = 1'b0;
        clear_logs();
        step(); step();
        chk("t7_busy", 32'(busy), 32'h0);
        chk("t7_strobes", 32'(slog.size()), 32'd0);

        // randomized bursts with contention, backpressure, aborts and spurious starts
        for (int b = 0; b < 40; b++) begin
            ready_pct = int'($urandom_range(20, 100));
            deny_pct  = int'($urandom_range(0, 60));
            begin_burst(($urandom_range(3) == 0) ? 15'(15'h7FF0 + 15'($urandom_range(15))) : 15'($urandom),
                        ($urandom_range(9) == 0) ? 0 : int'($urandom_range(1, 40)));
            step();
            n = 0;
            while ((m_busy || m_fetch || m_drain || m_done) && n < 3000) begin
                if ($urandom_range(199) == 0) abort = 1'b1;
                if ($urandom_range(15) == 0) begin_burst(15'($urandom), int'($urandom_range(0, 40)));
                step();
                n++;
            end
            if (n >= 3000) begin
                n_checks++; n_fail++;
                $display("FAIL random_burst_%0d: still active after 3000 cycles, required idle", b);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
